// File: rtl/debounce_multi_keys.sv
// -----------------------------------------------------------------------------
// debounce_multi_keys
//   Multi-channel front-panel button conditioner. Every channel synchronizes
//   its raw pin, debounces it on the shared tick_fast strobe, and produces
//   press/release edge pulses plus a long-press pulse and optional auto-repeat
//   pulses for fast time-setting. Channels are fully independent.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   tick_fast  in   one-clk strobe; all debounce and hold timing counts these
//   in_raw     in   [N_CH] raw asynchronous button inputs, active-high
//   out_deb    out  [N_CH] debounced level
//   press_p    out  [N_CH] one-clk pulse on debounced rise
//   release_p  out  [N_CH] one-clk pulse on debounced fall
//   long_p     out  [N_CH] one-clk pulse when a press has lasted LONG_COUNT ticks
//   rpt_p      out  [N_CH] one-clk pulse every REPEAT_COUNT ticks after long_p
//   held_long  out  [N_CH] high from long_p until the release
//
// Hold FSM (per channel)
//   state       | meaning
//   ST_IDLE     | debounced level low (or not yet committed high)
//   ST_PRESSED  | debounced high, counting toward long-press
//   ST_LONG     | long-press reached, counting auto-repeat intervals
// -----------------------------------------------------------------------------
module debounce_multi_keys #(
  parameter int N_CH         = 4,
  parameter int STABLE_COUNT = 2000,
  parameter int LONG_COUNT   = 200,
  parameter int REPEAT_COUNT = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_fast,
  input  logic [N_CH-1:0] in_raw,
  output logic [N_CH-1:0] out_deb,
  output logic [N_CH-1:0] press_p,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] long_p,
  output logic [N_CH-1:0] rpt_p,
  output logic [N_CH-1:0] held_long
);

  localparam int CNT_W    = $clog2(STABLE_COUNT + 1);
  localparam int HOLD_A   = (LONG_COUNT > REPEAT_COUNT) ? LONG_COUNT : REPEAT_COUNT;
  localparam int HOLD_MAX = (HOLD_A > 1) ? HOLD_A : 1;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(STABLE_COUNT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_COUNT - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_COUNT - 1);
  localparam logic [HOLD_W-1:0] RPT_LAST  = HOLD_W'((REPEAT_COUNT == 0) ? 0 : REPEAT_COUNT - 1);
  localparam bit                RPT_EN    = (REPEAT_COUNT != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } hold_state_e;

  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic              prev_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              deb_q;
    logic              press_q;
    logic              release_q;
    logic              long_q;
    logic              rpt_q;
    logic              held_q;
    hold_state_e       state_q;
    logic [HOLD_W-1:0] hold_cnt_q;

    logic stable;
    logic commit;
    logic rise;
    logic fall;

    // The commit fires on the strobe where the count steps from
    // STABLE_COUNT-1 to STABLE_COUNT, i.e. the (STABLE_COUNT+1)th strobe
    // that has seen the new level.
    assign stable = (sync2_q[i] == prev_q);
    assign commit = tick_fast && stable && (cnt_q == CNT_LAST) && (prev_q != deb_q);
    assign rise   = commit && prev_q;
    assign fall   = commit && !prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev_q    <= 1'b0;
        cnt_q     <= '0;
        deb_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (tick_fast) begin
          if (!stable) begin
            prev_q <= sync2_q[i];
            cnt_q  <= '0;
          end else if (cnt_q != CNT_SAT) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (commit) begin
            deb_q     <= prev_q;
            press_q   <= prev_q;
            release_q <= !prev_q;
          end
        end
      end
    end

    // A debounced fall wins over any long/repeat decision in the same strobe.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= ST_IDLE;
        hold_cnt_q <= '0;
        long_q     <= 1'b0;
        rpt_q      <= 1'b0;
        held_q     <= 1'b0;
      end else begin
        long_q <= 1'b0;
        rpt_q  <= 1'b0;
        if (fall) begin
          state_q    <= ST_IDLE;
          hold_cnt_q <= '0;
          held_q     <= 1'b0;
        end else if (tick_fast) begin
          case (state_q)
            ST_IDLE: begin
              if (rise) begin
                state_q    <= ST_PRESSED;
                hold_cnt_q <= '0;
              end
            end
            ST_PRESSED: begin
              if (hold_cnt_q == LONG_LAST) begin
                long_q     <= 1'b1;
                held_q     <= 1'b1;
                hold_cnt_q <= '0;
                state_q    <= ST_LONG;
              end else begin
                hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
              end
            end
            ST_LONG: begin
              if (RPT_EN) begin
                if (hold_cnt_q == RPT_LAST) begin
                  rpt_q      <= 1'b1;
                  hold_cnt_q <= '0;
                end else begin
                  hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                end
              end
            end
            default: begin
              state_q    <= ST_IDLE;
              hold_cnt_q <= '0;
              held_q     <= 1'b0;
            end
          endcase
        end
      end
    end

    assign out_deb[i]   = deb_q;
    assign press_p[i]   = press_q;
    assign release_p[i] = release_q;
    assign long_p[i]    = long_q;
    assign rpt_p[i]     = rpt_q;
    assign held_long[i] = held_q;
  end

endmodule

// File: tb/tb_debounce_multi_keys.sv
module tb_debounce_multi_keys;

  localparam int N_CH = 2;
  localparam int SC   = 4;
  localparam int LC   = 10;
  localparam int RC   = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            tick_fast = 1'b0;
  logic [N_CH-1:0] in_raw = '0;
  logic [N_CH-1:0] out_deb, press_p, release_p, long_p, rpt_p, held_long;

  always #5 clk = ~clk;

  debounce_multi_keys #(
    .N_CH(N_CH), .STABLE_COUNT(SC), .LONG_COUNT(LC), .REPEAT_COUNT(RC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_fast(tick_fast), .in_raw(in_raw),
    .out_deb(out_deb), .press_p(press_p), .release_p(release_p),
    .long_p(long_p), .rpt_p(rpt_p), .held_long(held_long)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobe = 0;

  // Reference model: run length of identical samples per channel, committed
  // level, and number of strobes elapsed since the rise committed.
  logic [N_CH-1:0] m_run_val, m_deb, m_hl;
  int              m_run_len [N_CH];
  int              m_held    [N_CH];
  logic [N_CH-1:0] e_press, e_rel, e_long, e_rpt;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @strobe %0d: observed %h expected %h", tag, n_strobe, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run_val = '0; m_deb = '0; m_hl = '0;
    e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0;
    for (int c = 0; c < N_CH; c++) begin
      m_run_len[c] = 0;
      m_held[c]    = 0;
    end
  endtask

  task automatic model_strobe(input logic [N_CH-1:0] raw);
    e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (raw[c] != m_run_val[c]) begin
        m_run_val[c] = raw[c];
        m_run_len[c] = 1;
      end else begin
        m_run_len[c]++;
      end
      if (m_run_len[c] == SC + 1 && m_run_val[c] != m_deb[c]) begin
        m_deb[c] = m_run_val[c];
        if (m_deb[c]) begin
          e_press[c] = 1'b1;
          m_held[c]  = 0;
        end else begin
          e_rel[c] = 1'b1;
          m_hl[c]  = 1'b0;
        end
      end else if (m_deb[c]) begin
        m_held[c]++;
        if (m_held[c] == LC) begin
          e_long[c] = 1'b1;
          m_hl[c]   = 1'b1;
        end else if (m_held[c] > LC && RC != 0 && ((m_held[c] - LC) % RC) == 0) begin
          e_rpt[c] = 1'b1;
        end
      end
    end
  endtask

  // One 4-clk strobe period; called and returning at a negedge.
  task automatic strobe(input logic [N_CH-1:0] raw);
    in_raw    = raw;
    tick_fast = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_pulses", 12'({press_p, release_p, long_p, rpt_p}), 12'h0);
    check("idle_level", 12'({out_deb, held_long}), 12'({m_deb, m_hl}));
    @(negedge clk);
    tick_fast = 1'b1;
    @(posedge clk);
    #1;
    n_strobe++;
    model_strobe(raw);
    check("out_deb",   12'(out_deb),   12'(m_deb));
    check("press_p",   12'(press_p),   12'(e_press));
    check("release_p", 12'(release_p), 12'(e_rel));
    check("long_p",    12'(long_p),    12'(e_long));
    check("rpt_p",     12'(rpt_p),     12'(e_rpt));
    check("held_long", 12'(held_long), 12'(m_hl));
    @(negedge clk);
    tick_fast = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check(tag, 12'({out_deb, press_p, release_p, long_p, rpt_p, held_long}), 12'h0);
    @(negedge clk);
    @(negedge clk);
    check(tag, 12'({out_deb, press_p, release_p, long_p, rpt_p, held_long}), 12'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_CH-1:0] cur;
    model_reset();
    in_raw = 2'b11;
    @(negedge clk);

    // 1. reset with both buttons held, then both qualify together
    do_reset("t1_reset");
    for (int k = 1; k <= 5; k++) begin
      strobe(2'b11);
      if (k == 4) check("t1_no_press_early", 12'(press_p), 12'h0);
    end
    check("t1_press", 12'(press_p), 12'h3);

    // 3./4./5. ch0 short press, ch1 long press with repeats, release on a repeat slot
    for (int s = 1; s <= 22; s++) begin
      cur[0] = (s <= 2);
      cur[1] = (s <= 17);
      strobe(cur);
      if (s == 7) begin
        check("t3_release_ch0", 12'(release_p), 12'h1);
        check("t3_no_long", 12'(held_long), 12'h0);
      end
      if (s == 10) check("t4_long_ch1", 12'({long_p, held_long}), 12'({2'b10, 2'b10}));
      if (s == 13 || s == 16 || s == 19) check("t4_rpt_ch1", 12'(rpt_p), 12'h2);
      if (s == 22) check("t5_release_over_rpt", 12'({release_p, rpt_p, held_long}), 12'({2'b10, 2'b00, 2'b00}));
    end

    // 2. bounce on ch0: 1,0,1 then steady
    strobe(2'b01);
    strobe(2'b00);
    strobe(2'b01);
    for (int b = 4; b <= 7; b++) begin
      strobe(2'b01);
      if (b == 6) check("t2_no_press_bounce", 12'(press_p), 12'h0);
    end
    check("t2_press_after_bounce", 12'(press_p), 12'h1);
    for (int k = 0; k < 5; k++) strobe(2'b00);
    check("t2_release", 12'(release_p), 12'h1);

    // 5. release commits exactly on T+16 where a repeat would fall
    for (int k = 0; k < 5; k++) strobe(2'b10);
    for (int s = 1; s <= 16; s++) begin
      strobe((s <= 11) ? 2'b10 : 2'b00);
      if (s == 13) check("t5_rpt_t13", 12'(rpt_p), 12'h2);
    end
    check("t5_release_t16", 12'({release_p, rpt_p, held_long, out_deb}), 12'({2'b10, 2'b00, 2'b00, 2'b00}));

    // 6. reset in the middle of a long press
    for (int k = 0; k < 5; k++) strobe(2'b10);
    for (int s = 1; s <= 12; s++) strobe(2'b10);
    check("t6_held_before_reset", 12'(held_long), 12'h2);
    do_reset("t6_reset");
    for (int k = 1; k <= 5; k++) strobe(2'b10);
    check("t6_repress", 12'(press_p), 12'h2);
    for (int s = 1; s <= 10; s++) strobe(2'b10);
    check("t6_long_after_reset", 12'(long_p), 12'h2);
    for (int k = 0; k < 5; k++) strobe(2'b00);

    // random phase: sticky levels with occasional toggles and rare resets
    cur = 2'b00;
    for (int r = 0; r < 400; r++) begin
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 6) == 0) cur[c] = ~cur[c];
      strobe(cur);
      if ($urandom_range(0, 149) == 0) do_reset("rand_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_multi_keys.md
Name: debounce_multi_keys

Overview:
- Multi-channel successor to the single-input debouncer, for the clock's front-panel buttons.
- Each channel synchronizes a raw button and debounces it on the shared tick_fast strobe.
- Each channel also emits one-clk press/release events, a long-press event and optional auto-repeat events (used for fast time-setting).
- Sits between the board pins and the time-set FSM.

Parameters:
- N_CH, 4: number of independent button channels (>=1).
- STABLE_COUNT, 2000: ticks the synchronized input must hold before the debounced level changes (>=1).
- LONG_COUNT, 200: ticks of held debounced level before long_p fires (>=1).
- REPEAT_COUNT, 40: ticks between rpt_p pulses after long_p; 0 disables repeat.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick_fast  in  1  one-clk strobe; all debounce and hold timing counts these strobes.
- in_raw  in  N_CH  raw asynchronous button inputs, active-high.
- out_deb  out  N_CH  debounced level per channel.
- press_p  out  N_CH  one-clk pulse on each debounced rise.
- release_p  out  N_CH  one-clk pulse on each debounced fall.
- long_p  out  N_CH  one-clk pulse when a press reaches LONG_COUNT ticks.
- rpt_p  out  N_CH  one-clk pulse every REPEAT_COUNT ticks after long_p while still held.
- held_long  out  N_CH  level; high from long_p until release.

Behaviour:
- Reset: all flops clear asynchronously to 0, including sync stages, prev, counters, FSM state (IDLE) and all outputs.
- Reset mid-press: the current press is discarded. A button still held after rst_n deasserts is reported as a fresh press once it re-qualifies.
- Synchronizer: two flops per channel, s1 <= in_raw, s2 <= s1, every clk.
- Debounce per channel, evaluated only on cycles where tick_fast=1:
  - If s2 != prev: prev <= s2, cnt <= 0.
  - Else if cnt != STABLE_COUNT: cnt <= cnt+1. When cnt == STABLE_COUNT-1 and prev != out_deb, out_deb <= prev.
  - cnt width is clog2(STABLE_COUNT+1) and cnt saturates at STABLE_COUNT.
- Debounce timing:
  - A new level commits on the (STABLE_COUNT+1)th consecutive strobe that sees it, counting the strobe that first observed the change.
  - Any glitch before then restarts the count; no output change occurs.
- Edge events:
  - press_p/release_p are registered alongside the out_deb update.
  - Each is high for exactly the first clk cycle of the new out_deb level.
- Hold FSM per channel, states IDLE, PRESSED, LONG; hold_cnt width is clog2(max(LONG_COUNT, REPEAT_COUNT, 1)+1).
  - IDLE -> PRESSED on debounced rise; hold_cnt <= 0. The committing strobe itself is not counted.
  - PRESSED, on a strobe: if hold_cnt == LONG_COUNT-1, pulse long_p, hold_cnt <= 0, go to LONG; else hold_cnt++.
  - LONG, on a strobe with REPEAT_COUNT != 0: if hold_cnt == REPEAT_COUNT-1, pulse rpt_p and set hold_cnt <= 0; else hold_cnt++.
  - LONG with REPEAT_COUNT == 0: hold_cnt is frozen.
  - held_long = (state == LONG).
  - Debounced fall from any state: go to IDLE, hold_cnt <= 0, held_long drops in the same cycle release_p is high.
- Resulting timing: with the rise committed on strobe T, long_p fires on strobe T+LONG_COUNT and rpt_p on strobes T+LONG_COUNT+k*REPEAT_COUNT, k>=1.
- Simultaneous events:
  - Release takes priority over long/repeat. long_p and rpt_p cannot coincide with release_p, and neither can fire in a strobe where out_deb falls.
  - Channels are fully independent; any combination of pulses on different channels may coincide.
- Pulses are never generated on non-tick cycles. All outputs are registered.

Test Plan:
Common setup for all scenarios: N_CH=2, STABLE_COUNT=4, LONG_COUNT=10, REPEAT_COUNT=3, tick_fast one clk in every 4.
1. Reset: hold rst_n=0 with in_raw=2'b11 -> all outputs 0. After release, out_deb[1:0] rises on the 5th strobe that sees s2=1. press_p = 2'b11 for one clk.
2. Bounce: ch0 toggles 1,0,1 on consecutive strobes, then stays 1 -> no press_p until 5 strobes after the last toggle. ch1 is unaffected throughout.
3. Short press: ch0 held for 6 strobes after commit, then released -> one press_p, no long_p, one release_p after re-qualification (5 strobes). held_long stays 0.
4. Long + repeat: ch1 held -> long_p on strobe T+10, rpt_p on T+13, T+16, T+19. held_long is 1 from T+10 until the cycle release_p fires.
5. Release priority: the release commits on the same strobe where rpt_p would fire (T+16) -> release_p=1 and rpt_p=0 in that cycle; state returns to IDLE.
6. Mid-press reset: assert rst_n=0 at T+12 while ch1 held -> held_long, out_deb and all pulses read 0 immediately. After rst_n deasserts: press_p fires after requalification, and long_p fires 10 strobes later.
